fft_frame_packer: RTL and testbench
===================================

FFT_FRAME_PACKER -- requirements
Module: fft_frame_packer

Interface
REQ-001 SHALL have parameter NB, default 16: width of each real/imag sample.
REQ-002 SHALL have parameter LANES, default 4: complex samples per output vector.
REQ-003 SHALL have parameter FRAME, default 32: samples per FFT frame; FRAME mod LANES = 0, FRAME >= 2*LANES.
REQ-004 CLK  in  1  sole clock, rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 START  in  1  frame-start pulse; its cycle is sample 0 when ED=1.
REQ-007 ED  in  1  input sample valid.
REQ-008 INV  in  1  inverse-FFT mode, sampled only when START=1.
REQ-009 DR, DI  in  NB each  real/imag input sample.
REQ-010 ORDY  in  1  downstream ready for vector.
REQ-011 OR, OI  out  NB*LANES each  packed vector; lane 0 in LSBs.
REQ-012 OVLD  out  1  vector valid.
REQ-013 OSTART, OLAST  out  1 each  vector is first / last of its frame (qualified by OVLD).
REQ-014 BUSY  out  1  frame fill in progress.
REQ-015 ERR  out  1  one-cycle pulse: frame aborted by early START.
REQ-016 OVF  out  1  one-cycle pulse: completed vector dropped, FIFO full.

Function
REQ-017 SHALL use states IDLE and FILL; IDLE->FILL on START=1; FILL->IDLE when sample FRAME-1 is accepted.
REQ-018 Sample accepted when ED=1 and (FILL or START=1); ED in IDLE without START SHALL be ignored.
REQ-019 Accepted sample k of frame SHALL go to lane k mod LANES of vector k/LANES.
REQ-020 When INV latched 1, each accepted sample SHALL be stored with DR and DI swapped (swap-IFFT); INV ignored mid-frame.
REQ-021 START=1 with ED=0 SHALL enter FILL with count 0 and no sample accepted.
REQ-022 START during FILL SHALL discard partial vector, restart count at 0 (accepting sample 0 if ED=1), relatch INV, pulse ERR next cycle; vectors already queued SHALL be kept.
REQ-023 Completed vector SHALL be pushed into 2-entry FIFO at the edge its last lane is accepted, with OSTART=(vector index 0), OLAST=(index FRAME/LANES-1).
REQ-024 Latency: last lane accepted at edge t, FIFO empty -> OVLD=1 in cycle after t.
REQ-025 Pop on OVLD=1 and ORDY=1; OR/OI/OSTART/OLAST SHALL hold stable while OVLD=1 and ORDY=0.
REQ-026 Push and pop same edge with FIFO full SHALL succeed (occupancy unchanged).
REQ-027 Push with FIFO full and no pop SHALL drop new vector, pulse OVF next cycle, leave FIFO contents intact.
REQ-028 BUSY SHALL equal (state==FILL).
REQ-029 No arithmetic on samples; widths pass through unchanged.

Reset
REQ-030 RST=1 SHALL asynchronously force IDLE, count 0, INV latch 0, FIFO empty, OVLD/OSTART/OLAST/BUSY/ERR/OVF=0, OR/OI=0.
REQ-031 RST mid-frame SHALL discard partial and queued vectors; first START after release starts clean frame.

Structure
REQ-032 Default NB/LANES/FRAME and state encoding SHALL reside in shared package fft_pkg.
REQ-033 FIFO SHALL be sub-module cplx_vec_fifo2 (2-entry, width 2*NB*LANES+2, valid/ready, full flag).
REQ-034 Packer SHALL be one always block for state/count, one for lane shift register; no latches.

Verification (NB=16, LANES=4, FRAME=32)
REQ-035 START+ED with DR=k, DI=100+k for k=0..31, ORDY=1 -> 8 vectors; vector0 OR lanes {3,2,1,0}, OSTART=1; vector7 OLAST=1; OVLD one cycle after each 4th sample; BUSY drops after k=31.
REQ-036 Same with INV=1 at START -> vector0 OR lanes {103,102,101,100}, OI lanes {3,2,1,0}.
REQ-037 ORDY=0 throughout full frame -> vectors 0,1 held, OVF pulses 6 times, after ORDY=1 vectors 0 then 1 pop in order.
REQ-038 START reasserted at k=10 -> ERR pulse; vectors 0,1 still delivered; samples 8,9 lost; new frame vector0 from next four samples with OSTART=1.
REQ-039 RST pulse at k=17 with 1 vector queued -> OVLD=0 immediately, no further vectors until new START.
REQ-040 ED toggling 1/0 every cycle during frame -> identical output vectors to REQ-035, frame completes in 63 cycles.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared defaults and state encoding for the FFT frame packer.
package fft_pkg;
  localparam int NB_D    = 16;
  localparam int LANES_D = 4;
  localparam int FRAME_D = 32;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;
endpackage

// File: rtl/cplx_vec_fifo2.sv
// Two-entry vector FIFO with valid/ready read side and a full flag.
module cplx_vec_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wvld,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         rvld,
  input  logic         rrdy,
  output logic [W-1:0] rdata
);
  logic [W-1:0] m0, m1;
  logic         rp, wp;
  logic [1:0]   cnt;
  logic         push, pop;

  assign full  = (cnt == 2'd2);
  assign rvld  = (cnt != 2'd0);
  assign pop   = rvld && rrdy;
  // a pop frees the slot the same edge, so full+pop still takes the push
  assign push  = wvld && (!full || pop);
  assign rdata = rp ? m1 : m0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0  <= '0;
      m1  <= '0;
      rp  <= 1'b0;
      wp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        if (wp) m1 <= wdata;
        else    m0 <= wdata;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/fft_frame_packer.sv
// Packs a serial complex sample stream into LANES-wide vectors per frame.
module fft_frame_packer
  import fft_pkg::*;
#(
  parameter int NB    = NB_D,
  parameter int LANES = LANES_D,
  parameter int FRAME = FRAME_D
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                ED,
  input  logic                INV,
  input  logic [NB-1:0]       DR,
  input  logic [NB-1:0]       DI,
  input  logic                ORDY,
  output logic [NB*LANES-1:0] OR,
  output logic [NB*LANES-1:0] OI,
  output logic                OVLD,
  output logic                OSTART,
  output logic                OLAST,
  output logic                BUSY,
  output logic                ERR,
  output logic                OVF
);
  localparam int VW = NB * LANES;
  localparam int W  = 2 * VW + 2;
  localparam int NV = FRAME / LANES;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = $clog2(NV);

  state_t        state, state_n;
  logic [LW-1:0] lane, l_cur;
  logic [CW-1:0] vec, v_cur;
  logic          inv_q, inv_cur;
  logic          take, lane_end, done;
  logic [NB-1:0] s_r, s_i;
  logic [VW-1:0] sr_r, sr_i, nv_r, nv_i;
  logic [W-1:0]  wdata, rdata;
  logic          fifo_full;

  always_comb begin
    state_n  = state;
    take     = ED && (state == FILL || START);
    l_cur    = START ? '0 : lane;
    v_cur    = START ? '0 : vec;
    inv_cur  = START ? INV : inv_q;
    s_r      = inv_cur ? DI : DR;
    s_i      = inv_cur ? DR : DI;
    lane_end = take && (l_cur == LW'(LANES - 1));
    done     = lane_end && (v_cur == CW'(NV - 1));
    nv_r     = {s_r, sr_r[VW-1:NB]};
    nv_i     = {s_i, sr_i[VW-1:NB]};
    wdata    = {v_cur == '0, v_cur == CW'(NV - 1), nv_i, nv_r};
    if (START)     state_n = FILL;
    else if (done) state_n = IDLE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      lane  <= '0;
      vec   <= '0;
      inv_q <= 1'b0;
      ERR   <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      state <= state_n;
      ERR   <= START && (state == FILL);
      OVF   <= lane_end && fifo_full && !(OVLD && ORDY);
      if (START) inv_q <= INV;
      if (take) begin
        if (lane_end) begin
          lane <= '0;
          vec  <= done ? '0 : v_cur + CW'(1);
        end else begin
          lane <= l_cur + LW'(1);
          vec  <= v_cur;
        end
      end else if (START) begin
        lane <= '0;
        vec  <= '0;
      end
    end
  end

  // old lanes shift out naturally, so an aborted partial needs no clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr_r <= '0;
      sr_i <= '0;
    end else if (take) begin
      sr_r <= nv_r;
      sr_i <= nv_i;
    end
  end

  cplx_vec_fifo2 #(.W(W)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .wvld  (lane_end),
    .wdata (wdata),
    .full  (fifo_full),
    .rvld  (OVLD),
    .rrdy  (ORDY),
    .rdata (rdata)
  );

  assign OR     = rdata[VW-1:0];
  assign OI     = rdata[2*VW-1:VW];
  assign OLAST  = rdata[2*VW];
  assign OSTART = rdata[2*VW+1];
  assign BUSY   = (state == FILL);
endmodule

// File: tb/tb_fft_frame_packer.sv
// Randomized and directed bench for fft_frame_packer with a queue model.
module tb_fft_frame_packer;
  localparam int NB    = 16;
  localparam int LANES = 4;
  localparam int FRAME = 32;
  localparam int VW    = NB * LANES;

  typedef struct {
    logic [VW-1:0] r;
    logic [VW-1:0] i;
    logic          st;
    logic          la;
  } vec_t;

  logic          CLK = 1'b0;
  logic          RST, START, ED, INV, ORDY;
  logic [NB-1:0] DR, DI;
  logic [VW-1:0] OR, OI;
  logic          OVLD, OSTART, OLAST, BUSY, ERR, OVF;

  fft_frame_packer #(.NB(NB), .LANES(LANES), .FRAME(FRAME)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ED(ED), .INV(INV),
    .DR(DR), .DI(DI), .ORDY(ORDY), .OR(OR), .OI(OI),
    .OVLD(OVLD), .OSTART(OSTART), .OLAST(OLAST),
    .BUSY(BUSY), .ERR(ERR), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  int nchk = 0;
  int nfail = 0;

  bit   m_fill, m_inv, m_err, m_ovf;
  int   m_k;
  logic [NB-1:0] part_r[$], part_i[$];
  vec_t mq[$];
  vec_t got[$];
  int   ovf_seen;

  function automatic void chk(string n, logic [VW-1:0] a, logic [VW-1:0] e);
    nchk++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction

  function automatic logic [VW-1:0] pack(int l3, int l2, int l1, int l0);
    logic [VW-1:0] v;
    v = {NB'(l3), NB'(l2), NB'(l1), NB'(l0)};
    return v;
  endfunction

  task automatic model_reset();
    m_fill = 0; m_inv = 0; m_err = 0; m_ovf = 0; m_k = 0;
    part_r.delete(); part_i.delete(); mq.delete();
  endtask

  task automatic model_step();
    bit   pop;
    vec_t v;
    if (OVLD && ORDY) begin
      v.r = OR; v.i = OI; v.st = OSTART; v.la = OLAST;
      got.push_back(v);
    end
    if (OVF) ovf_seen++;
    pop   = (mq.size() > 0) && ORDY;
    m_err = START && m_fill;
    m_ovf = 0;
    if (pop) void'(mq.pop_front());
    if (START) begin
      m_fill = 1; m_k = 0; m_inv = INV;
      part_r.delete(); part_i.delete();
    end
    if (ED && m_fill) begin
      part_r.push_back(m_inv ? DI : DR);
      part_i.push_back(m_inv ? DR : DI);
      if (m_k % LANES == LANES - 1) begin
        for (int l = 0; l < LANES; l++) begin
          v.r[l*NB +: NB] = part_r[l];
          v.i[l*NB +: NB] = part_i[l];
        end
        v.st = (m_k / LANES == 0);
        v.la = (m_k / LANES == FRAME / LANES - 1);
        part_r.delete(); part_i.delete();
        if (mq.size() < 2) mq.push_back(v);
        else m_ovf = 1;
      end
      m_k++;
      if (m_k == FRAME) begin
        m_fill = 0; m_k = 0;
      end
    end
  endtask

  always @(negedge CLK) begin
    chk("busy", VW'(BUSY), VW'(m_fill));
    chk("err", VW'(ERR), VW'(m_err));
    chk("ovf", VW'(OVF), VW'(m_ovf));
    chk("ovld", VW'(OVLD), VW'(mq.size() > 0));
    if (OVLD && mq.size() > 0) begin
      chk("or", OR, mq[0].r);
      chk("oi", OI, mq[0].i);
      chk("ostart", VW'(OSTART), VW'(mq[0].st));
      chk("olast", VW'(OLAST), VW'(mq[0].la));
    end
  end

  task automatic step(input bit s, e, iv, input int r, i, input bit rd);
    @(negedge CLK); #1;
    START = s; ED = e; INV = iv;
    DR = NB'(r); DI = NB'(i); ORDY = rd;
    model_step();
  endtask

  task automatic do_reset();
    @(negedge CLK); #1;
    RST = 1; START = 0; ED = 0; ORDY = 0;
    model_reset();
    #1;
    chk("rst_ovld", VW'(OVLD), '0);
    chk("rst_busy", VW'(BUSY), '0);
    chk("rst_or", OR, '0);
    @(negedge CLK); #1;
    RST = 0;
  endtask

  task automatic idle(int n, bit rd);
    for (int c = 0; c < n; c++) step(0, 0, 0, 0, 0, rd);
  endtask

  initial begin
    RST = 1; START = 0; ED = 0; INV = 0; DR = 0; DI = 0; ORDY = 0;
    model_reset();
    ovf_seen = 0;
    repeat (2) @(negedge CLK);
    chk("reset_or", OR, '0);
    chk("reset_oi", OI, '0);
    #1 RST = 0;

    for (int c = 0; c < 4; c++) step(0, 1, 0, 55, 66, 1);
    idle(2, 1);

    got.delete();
    for (int k = 0; k < FRAME; k++) step(k == 0, 1, 0, k, 100 + k, 1);
    idle(4, 1);
    chk("f0_count", VW'(got.size()), VW'(8));
    if (got.size() == 8) begin
      chk("f0_v0_or", got[0].r, pack(3, 2, 1, 0));
      chk("f0_v0_oi", got[0].i, pack(103, 102, 101, 100));
      chk("f0_v0_st", VW'(got[0].st), VW'(1));
      chk("f0_v7_la", VW'(got[7].la), VW'(1));
      chk("f0_v7_or", got[7].r, pack(31, 30, 29, 28));
    end

    got.delete();
    for (int k = 0; k < FRAME; k++) step(k == 0, 1, k == 0, k, 100 + k, 1);
    idle(4, 1);
    chk("inv_count", VW'(got.size()), VW'(8));
    if (got.size() > 0) begin
      chk("inv_v0_or", got[0].r, pack(103, 102, 101, 100));
      chk("inv_v0_oi", got[0].i, pack(3, 2, 1, 0));
    end

    got.delete(); ovf_seen = 0;
    for (int k = 0; k < FRAME; k++) step(k == 0, 1, 0, k, 100 + k, 0);
    idle(3, 0);
    chk("bp_ovf_pulses", VW'(ovf_seen), VW'(6));
    idle(4, 1);
    chk("bp_count", VW'(got.size()), VW'(2));
    if (got.size() == 2) begin
      chk("bp_v0_or", got[0].r, pack(3, 2, 1, 0));
      chk("bp_v1_or", got[1].r, pack(7, 6, 5, 4));
    end

    got.delete();
    for (int k = 0; k < 10 + FRAME; k++) step(k == 0 || k == 10, 1, 0, k, 100 + k, 1);
    idle(4, 1);
    chk("abort_count", VW'(got.size()), VW'(10));
    if (got.size() == 10) begin
      chk("abort_v1_or", got[1].r, pack(7, 6, 5, 4));
      chk("abort_new_v0", got[2].r, pack(13, 12, 11, 10));
      chk("abort_new_st", VW'(got[2].st), VW'(1));
    end

    for (int k = 0; k < 17; k++) step(k == 0, 1, 0, k, 100 + k, k < 14);
    do_reset();
    for (int c = 0; c < 6; c++) step(0, 1, 0, c, c, 1);
    idle(2, 1);

    got.delete();
    for (int c = 0; c < 2 * FRAME - 1; c++)
      step(c == 0, c % 2 == 0, 0, c / 2, 100 + c / 2, 1);
    chk("toggle_busy_end", VW'(m_fill), '0);
    idle(4, 1);
    chk("toggle_count", VW'(got.size()), VW'(8));
    if (got.size() == 8) begin
      chk("toggle_v0_or", got[0].r, pack(3, 2, 1, 0));
      chk("toggle_v7_la", VW'(got[7].la), VW'(1));
    end

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, $urandom, $urandom,
                $urandom_range(0, 2) != 0);
    end
    idle(4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
